// File: rtl/i2c_target_regs.sv
// I2C target exposing a small register window. The first byte after the
// address sets the register pointer. Further write bytes go out on a
// one-clock wr_valid strobe. Reads return rd_data at the pointer.
// The pointer auto-increments modulo NREGS in both directions.
module i2c_target_regs #(
    parameter logic [6:0]  TARGET_ADDR = 7'h2A,
    parameter int unsigned NREGS       = 16,
    parameter int unsigned PW          = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          scl_i,
    output logic          scl_o,
    input  logic          sda_i,
    output logic          sda_o,
    output logic          wr_valid,
    output logic [PW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic [PW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic          busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
    } state_t;

    // [0] and [1] form the synchroniser; [2] is the delayed copy for edge detection
    logic [2:0]    scl_sync_q, sda_sync_q;
    state_t        state_q;
    logic [3:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic [PW-1:0] ptr_q;
    logic          rw_q;
    logic          mack_q;
    logic          sda_o_q;
    logic          wr_valid_q;
    logic [PW-1:0] wr_addr_q;
    logic [7:0]    wr_data_q;
    logic          busy_q;

    logic          scl_now, scl_prev, sda_now, sda_prev;
    logic          scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]    shift_d;
    logic [PW-1:0] ptr_d;

    assign scl_now   = scl_sync_q[1];
    assign scl_prev  = scl_sync_q[2];
    assign sda_now   = sda_sync_q[1];
    assign sda_prev  = sda_sync_q[2];
    assign scl_rise  = scl_now & ~scl_prev;
    assign scl_fall  = ~scl_now & scl_prev;
    assign start_det = scl_now & scl_prev & sda_prev & ~sda_now;
    assign stop_det  = scl_now & scl_prev & ~sda_prev & sda_now;

    assign shift_d = {shift_q[6:0], sda_now};
    assign ptr_d   = (ptr_q == PW'(NREGS - 1)) ? '0 : ptr_q + PW'(1);

    assign scl_o    = 1'b1;
    assign sda_o    = sda_o_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign rd_addr  = ptr_q;
    assign busy     = busy_q;

    // Pad synchronisers plus the delayed copy; idle bus level is high
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it sits inside the clocked block rather than in the sensitivity list.
        if (reset) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
        end else begin
            // NOTE: sequential state uses <= so every flop samples the pre-edge value of its neighbour.
            scl_sync_q <= {scl_sync_q[1:0], scl_i};
            sda_sync_q <= {sda_sync_q[1:0], sda_i};
        end
    end

    // Protocol FSM: bits sampled on SCL rise, SDA changed only after SCL fall
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            mack_q     <= 1'b0;
            sda_o_q    <= 1'b1;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            wr_valid_q <= 1'b0;
            if (start_det) begin
                // Repeated START keeps the pointer so a read can follow a pointer write
                state_q   <= ADDR;
                bit_cnt_q <= '0;
                sda_o_q   <= 1'b1;
                busy_q    <= 1'b0;
            end else if (stop_det) begin
                state_q   <= IDLE;
                bit_cnt_q <= '0;
                sda_o_q   <= 1'b1;
                busy_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE, WAIT: begin
                        sda_o_q <= 1'b1;
                    end
                    ADDR: begin
                        if (scl_rise) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && bit_cnt_q == 4'd8) begin
                            bit_cnt_q <= '0;
                            if (shift_q[7:1] == TARGET_ADDR) begin
                                state_q <= ADDR_ACK;
                                rw_q    <= shift_q[0];
                                sda_o_q <= 1'b0;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= WAIT;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt_q <= '0;
                            if (rw_q) begin
                                // Pointer is stable here, so rd_data is valid for the first bit
                                state_q <= RDATA;
                                shift_q <= {rd_data[6:0], 1'b0};
                                sda_o_q <= rd_data[7];
                            end else begin
                                state_q <= PTR;
                                sda_o_q <= 1'b1;
                            end
                        end
                    end
                    PTR: begin
                        if (scl_rise) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && bit_cnt_q == 4'd8) begin
                            bit_cnt_q <= '0;
                            ptr_q     <= shift_q[PW-1:0];
                            sda_o_q   <= 1'b0;
                            state_q   <= PTR_ACK;
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            bit_cnt_q <= '0;
                            sda_o_q   <= 1'b1;
                            state_q   <= WDATA;
                        end
                    end
                    WDATA: begin
                        if (scl_rise) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && bit_cnt_q == 4'd8) begin
                            // Only a complete byte reaches here; aborts leave via START/STOP
                            bit_cnt_q  <= '0;
                            wr_valid_q <= 1'b1;
                            wr_addr_q  <= ptr_q;
                            wr_data_q  <= shift_q;
                            ptr_q      <= ptr_d;
                            sda_o_q    <= 1'b0;
                            state_q    <= WDATA_ACK;
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                bit_cnt_q <= '0;
                                sda_o_q   <= 1'b1;
                                state_q   <= RDATA_ACK;
                            end else if (bit_cnt_q != 4'd0) begin
                                sda_o_q <= shift_q[7];
                                shift_q <= {shift_q[6:0], 1'b0};
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            // Advance on ACK at the rise so rd_data settles before the fall
                            mack_q <= ~sda_now;
                            if (!sda_now) ptr_q <= ptr_d;
                        end else if (scl_fall) begin
                            bit_cnt_q <= '0;
                            if (mack_q) begin
                                state_q <= RDATA;
                                shift_q <= {rd_data[6:0], 1'b0};
                                sda_o_q <= rd_data[7];
                            end else begin
                                state_q <= WAIT;
                                sda_o_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        sda_o_q <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
